// File: rtl/tl_pkg.sv
// Shared types, sizes and helpers for the traffic light monitor.
package tl_pkg;

  localparam int unsigned LEN_W          = 8;
  localparam int unsigned CYCLE_W        = 16;
  localparam int unsigned DEF_RED_LEN    = 21;
  localparam int unsigned DEF_GREEN_LEN  = 21;
  localparam int unsigned DEF_YELLOW_LEN = 4;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_RED    = 2'b01,
    PH_GREEN  = 2'b10,
    PH_YELLOW = 2'b11
  } phase_e;

  // Exactly one lamp lit decodes to its colour; anything else maps to idle.
  function automatic phase_e decode_lamps(input logic red, input logic green, input logic yellow);
    phase_e ph;
    ph = PH_IDLE;
    case ({red, green, yellow})
      3'b100:  ph = PH_RED;
      3'b010:  ph = PH_GREEN;
      3'b001:  ph = PH_YELLOW;
      default: ph = PH_IDLE;
    endcase
    return ph;
  endfunction

  function automatic logic legal_change(input phase_e from_ph, input phase_e to_ph);
    return ((from_ph == PH_RED)    && (to_ph == PH_GREEN))  ||
           ((from_ph == PH_GREEN)  && (to_ph == PH_YELLOW)) ||
           ((from_ph == PH_YELLOW) && (to_ph == PH_RED));
  endfunction

endpackage

// File: rtl/tl_len_counter.sv
// 8-bit saturating phase length counter: clear beats load-one beats increment.
module tl_len_counter
  import tl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_one,
  input  logic             inc,
  input  logic             clr,
  output logic [LEN_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load_one) begin
      count <= LEN_W'(1);
    end else if (inc && (count != '1)) begin
      count <= count + LEN_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches lamp drives, tracks phase lengths and flags order/timing/one-hot errors.
// Define TL_MON_CYCLE_CNT_EN to build the completed-round counter on cycle_cnt.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int unsigned RED_LEN    = DEF_RED_LEN,
  parameter int unsigned GREEN_LEN  = DEF_GREEN_LEN,
  parameter int unsigned YELLOW_LEN = DEF_YELLOW_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               red_on,
  input  logic               green_on,
  input  logic               yellow_on,
  input  logic               err_clr,
  output phase_e             phase,
  output logic               phase_done,
  output logic [LEN_W-1:0]   last_len,
  output logic               err_onehot,
  output logic               err_order,
  output logic               err_timing,
  output logic [CYCLE_W-1:0] cycle_cnt
);

  logic             valid;
  phase_e           sample;
  logic             same;
  logic             change;
  logic             ending;
  logic             checked;
  logic             checked_end;
  logic             order_bad;
  logic             timing_bad;
  logic [LEN_W-1:0] len_cnt;

  function automatic int unsigned required_len(input phase_e ph);
    int unsigned req;
    req = 0;
    case (ph)
      PH_RED:    req = RED_LEN;
      PH_GREEN:  req = GREEN_LEN;
      PH_YELLOW: req = YELLOW_LEN;
      default:   req = 0;
    endcase
    return req;
  endfunction

  always_comb begin
    sample      = decode_lamps(red_on, green_on, yellow_on);
    valid       = (sample != PH_IDLE);
    same        = valid && (sample == phase);
    change      = valid && (sample != phase);
    ending      = change && (phase != PH_IDLE);
    // The first phase after idle is partial, so its end is not judged.
    checked_end = ending && checked;
    order_bad   = checked_end && !legal_change(phase, sample);
    timing_bad  = checked_end && (32'(len_cnt) != required_len(phase));
  end

  tl_len_counter u_len_counter (
    .clk      (clk),
    .reset    (reset),
    .load_one (change),
    .inc      (same),
    .clr      (!valid),
    .count    (len_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= PH_IDLE;
      checked    <= 1'b0;
      phase_done <= 1'b0;
      last_len   <= '0;
      err_onehot <= 1'b0;
      err_order  <= 1'b0;
      err_timing <= 1'b0;
    end else begin
      phase_done <= ending;
      if (!valid) begin
        phase   <= PH_IDLE;
        checked <= 1'b0;
      end else if (change) begin
        phase   <= sample;
        checked <= (phase != PH_IDLE);
      end
      if (ending) begin
        last_len <= len_cnt;
      end
      // A new error outranks a simultaneous clear.
      err_onehot <= (err_onehot && !err_clr) || !valid;
      err_order  <= (err_order  && !err_clr) || order_bad;
      err_timing <= (err_timing && !err_clr) || timing_bad;
    end
  end

`ifdef TL_MON_CYCLE_CNT_EN
  logic round_done;

  assign round_done = checked_end && (phase == PH_YELLOW) && (sample == PH_RED) && !timing_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (round_done) begin
      cycle_cnt <= cycle_cnt + CYCLE_W'(1);
    end
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: expected phase lengths queued on each colour change, popped on phase_done.
module tb_traffic_light_monitor;
  import tl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        red_on, green_on, yellow_on;
  logic        err_clr;
  phase_e      phase;
  logic        phase_done;
  logic [7:0]  last_len;
  logic        err_onehot, err_order, err_timing;
  logic [15:0] cycle_cnt;

  int checks   = 0;
  int failures = 0;

  int     exp_q[$];
  phase_e tb_ph     = PH_IDLE;
  int     tb_len    = 0;
  bit     tb_chk    = 1'b0;
  int     exp_rounds = 0;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;

  traffic_light_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .red_on     (red_on),
    .green_on   (green_on),
    .yellow_on  (yellow_on),
    .err_clr    (err_clr),
    .phase      (phase),
    .phase_done (phase_done),
    .last_len   (last_len),
    .err_onehot (err_onehot),
    .err_order  (err_order),
    .err_timing (err_timing),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic phase_e colour_of(input logic [2:0] l);
    if (l == L_RED)    return PH_RED;
    if (l == L_GREEN)  return PH_GREEN;
    if (l == L_YELLOW) return PH_YELLOW;
    return PH_IDLE;
  endfunction

  function automatic int exp_cycles();
`ifdef TL_MON_CYCLE_CNT_EN
    return exp_rounds;
`else
    return 0;
`endif
  endfunction

  // Hold a lamp pattern for n rising edges, recording what the monitor should report.
  task automatic drive(input logic [2:0] l, input int n, input logic clr);
    phase_e c;
    c = colour_of(l);
    if (c == PH_IDLE) begin
      tb_ph  = PH_IDLE;
      tb_len = 0;
      tb_chk = 1'b0;
    end else if (c != tb_ph) begin
      if (tb_ph != PH_IDLE) begin
        exp_q.push_back((tb_len > 255) ? 255 : tb_len);
        if (tb_chk && (tb_ph == PH_YELLOW) && (c == PH_RED) && (tb_len == 4)) exp_rounds++;
      end
      tb_chk = (tb_ph != PH_IDLE);
      tb_ph  = c;
      tb_len = n;
    end else begin
      tb_len += n;
    end
    {red_on, green_on, yellow_on} = l;
    err_clr = clr;
    repeat (n) @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic oh, input logic ord, input logic tim);
    check({tag, "_onehot"}, 32'(err_onehot), 32'(oh));
    check({tag, "_order"},  32'(err_order),  32'(ord));
    check({tag, "_timing"}, 32'(err_timing), 32'(tim));
  endtask

  always @(negedge clk) begin
    if (!reset && phase_done) begin
      if (exp_q.size() == 0) check("done_queue", 32'(exp_q.size()), 32'd1);
      else                   check("last_len", 32'(last_len), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {red_on, green_on, yellow_on} = L_RED;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", 32'(phase), 32'(PH_IDLE));
    check("rst_done", 32'(phase_done), 32'd0);
    check("rst_last_len", 32'(last_len), 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_cycle", 32'(cycle_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full legal round: first red unchecked, then checked green/yellow.
    drive(L_RED, 21, 1'b0);
    drive(L_GREEN, 21, 1'b0);
    drive(L_YELLOW, 4, 1'b0);
    drive(L_RED, 5, 1'b0);
    @(negedge clk);
    check("s1_phase", 32'(phase), 32'(PH_RED));
    check_flags("s1", 1'b0, 1'b0, 1'b0);
    check("s1_cycle", 32'(cycle_cnt), 32'(exp_cycles()));

    // RED -> YELLOW is out of order.
    drive(L_RED, 16, 1'b0);
    drive(L_YELLOW, 1, 1'b0);
    check("s2_phase", 32'(phase), 32'(PH_YELLOW));
    check_flags("s2", 1'b0, 1'b1, 1'b0);
    drive(L_YELLOW, 2, 1'b0);
    drive(L_YELLOW, 1, 1'b1);
    check_flags("s2_clr", 1'b0, 1'b0, 1'b0);
    drive(L_RED, 21, 1'b0);
    check("s2_cycle", 32'(cycle_cnt), 32'(exp_cycles()));

    // Short green.
    drive(L_GREEN, 19, 1'b0);
    drive(L_YELLOW, 1, 1'b0);
    check_flags("s3", 1'b0, 1'b0, 1'b1);
    check("s3_last_len", 32'(last_len), 32'd19);
    drive(L_YELLOW, 2, 1'b0);
    drive(L_YELLOW, 1, 1'b1);

    // Two lamps at once, then an unchecked partial red.
    drive(3'b110, 1, 1'b0);
    check("s4_phase", 32'(phase), 32'(PH_IDLE));
    check_flags("s4", 1'b1, 1'b0, 1'b0);
    drive(L_RED, 9, 1'b0);
    drive(L_RED, 1, 1'b1);
    check_flags("s4_clr", 1'b0, 1'b0, 1'b0);
    drive(L_GREEN, 21, 1'b0);
    check_flags("s4_red_end", 1'b0, 1'b0, 1'b0);
    drive(L_YELLOW, 4, 1'b0);

    // Clear coinciding with a YELLOW -> GREEN violation.
    drive(L_GREEN, 1, 1'b1);
    check_flags("s5_same_cycle", 1'b0, 1'b1, 1'b0);
    drive(L_GREEN, 1, 1'b0);
    drive(L_GREEN, 1, 1'b1);
    check_flags("s5_clr", 1'b0, 1'b0, 1'b0);

    // Saturating 300-cycle red.
    drive(L_RED, 1, 1'b0);
    check_flags("s6_bad_green", 1'b0, 1'b1, 1'b1);
    drive(L_RED, 1, 1'b1);
    drive(L_RED, 298, 1'b0);
    check_flags("s6_pre", 1'b0, 1'b0, 1'b0);
    drive(L_GREEN, 1, 1'b0);
    check("s6_last_len", 32'(last_len), 32'd255);
    check_flags("s6", 1'b0, 1'b0, 1'b1);
    drive(L_GREEN, 4, 1'b0);

    // Reset mid-green.
    reset = 1'b1;
    tb_ph = PH_IDLE;
    tb_len = 0;
    tb_chk = 1'b0;
    exp_rounds = 0;
    #1;
    check("mid_rst_phase", 32'(phase), 32'(PH_IDLE));
    check("mid_rst_done", 32'(phase_done), 32'd0);
    check("mid_rst_last_len", 32'(last_len), 32'd0);
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
    check("mid_rst_cycle", 32'(cycle_cnt), 32'd0);
    @(negedge clk);
    {red_on, green_on, yellow_on} = L_RED;
    reset = 1'b0;
    drive(L_RED, 3, 1'b0);
    drive(L_GREEN, 2, 1'b0);
    @(negedge clk);
    check("post_rst_phase", 32'(phase), 32'(PH_GREEN));
    check_flags("post_rst", 1'b0, 1'b0, 1'b0);
    check("post_rst_last_len", 32'(last_len), 32'd3);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
